// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the core's instruction and data ports onto one
// single-ported physical memory, data first, with a starvation guard.
//
// Ports:
//   clk, rst (sync, active-low)
//   imem_*  : instruction read port (address/read in, rdata/resp out)
//   dmem_*  : data port (address/wdata/read/write/byte_enable in,
//             rdata/resp out)
//   pmem_*  : physical memory port (registered request out,
//             rdata/resp in)
module mem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] imem_address,
    input  logic             imem_read,
    output logic [WIDTH-1:0] imem_rdata,
    output logic             imem_resp,
    input  logic [WIDTH-1:0] dmem_address,
    input  logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_read,
    input  logic             dmem_write,
    input  logic [3:0]       dmem_byte_enable,
    output logic [WIDTH-1:0] dmem_rdata,
    output logic             dmem_resp,
    output logic [WIDTH-1:0] pmem_address,
    output logic [WIDTH-1:0] pmem_wdata,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [3:0]       pmem_byte_enable,
    input  logic [WIDTH-1:0] pmem_rdata,
    input  logic             pmem_resp
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_D,
        SERVE_I
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]       be_q, be_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             data_req;
    logic             data_win;

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        data_req     = dmem_read | dmem_write;
        // Data wins unless a fetch has already waited through LIMIT grants.
        data_win     = data_req &&
                       (!imem_read || (starve_cnt_q < LIMIT_C));

        unique case (state_q)
            IDLE: begin
                if (data_win) begin
                    state_d = SERVE_D;
                    addr_d  = dmem_address;
                    wdata_d = dmem_wdata;
                    be_d    = dmem_byte_enable;
                    wr_d    = dmem_write;
                    rd_d    = !dmem_write;
                    if (imem_read && (starve_cnt_q != LIMIT_C))
                        starve_cnt_d = starve_cnt_q + CW'(1);
                end else if (imem_read) begin
                    state_d      = SERVE_I;
                    addr_d       = imem_address;
                    be_d         = 4'b1111;
                    rd_d         = 1'b1;
                    wr_d         = 1'b0;
                    starve_cnt_d = '0;
                end
            end
            SERVE_D, SERVE_I: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
        end
    end

    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;
    assign pmem_read        = rd_q;
    assign pmem_write       = wr_q;

    // Responses only while the matching access is in flight.
    assign imem_resp  = pmem_resp && (state_q == SERVE_I);
    assign dmem_resp  = pmem_resp && (state_q == SERVE_D);
    assign imem_rdata = pmem_rdata;
    assign dmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, all
// checked every cycle against a transaction-level arbiter model.
module tb_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address;
    logic        imem_read;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] pmem_address;
    logic [31:0] pmem_wdata;
    logic        pmem_read;
    logic        pmem_write;
    logic [3:0]  pmem_byte_enable;
    logic [31:0] pmem_rdata;
    logic        pmem_resp;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk),
        .rst(rst),
        .imem_address(imem_address),
        .imem_read(imem_read),
        .imem_rdata(imem_rdata),
        .imem_resp(imem_resp),
        .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata),
        .dmem_read(dmem_read),
        .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata),
        .dmem_resp(dmem_resp),
        .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_byte_enable(pmem_byte_enable),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: who owns the memory (0 none, 1 data, 2 instr), the
    // access it issued, and how many data grants a fetch has waited.
    int          m_own    = 0;
    int          m_starve = 0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [3:0]  m_be     = '0;
    logic        m_rd     = 1'b0;
    logic        m_wr     = 1'b0;

    bit i_pend, d_pend, d_r, d_w;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        int          own = m_own;
        int          stv = m_starve;
        logic [31:0] a   = m_addr;
        logic [31:0] w   = m_wdata;
        logic [3:0]  b   = m_be;
        logic        r   = m_rd;
        logic        wr  = m_wr;
        if (!rst) begin
            own = 0; stv = 0; a = '0; w = '0; b = '0; r = 0; wr = 0;
        end else if (own == 0) begin
            if ((dmem_read || dmem_write) && (!imem_read || stv < LIM)) begin
                own = 1;
                a = dmem_address; w = dmem_wdata; b = dmem_byte_enable;
                wr = dmem_write; r = !dmem_write;
                if (imem_read) stv = (stv + 1 > LIM) ? LIM : stv + 1;
            end else if (imem_read) begin
                own = 2;
                a = imem_address; b = 4'hF; r = 1; wr = 0;
                stv = 0;
            end
        end else if (pmem_resp) begin
            own = 0; r = 0; wr = 0;
        end
        @(posedge clk);
        #1;
        m_own = own; m_starve = stv; m_addr = a; m_wdata = w;
        m_be = b; m_rd = r; m_wr = wr;
    endtask

    task automatic settle_check();
        logic ei, ed;
        #1;
        ei = (m_own == 2) && pmem_resp;
        ed = (m_own == 1) && pmem_resp;
        chk("pmem_read", 32'(pmem_read), 32'(m_rd));
        chk("pmem_write", 32'(pmem_write), 32'(m_wr));
        chk("pmem_address", pmem_address, m_addr);
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("pmem_be", 32'(pmem_byte_enable), 32'(m_be));
        chk("imem_resp", 32'(imem_resp), 32'(ei));
        chk("dmem_resp", 32'(dmem_resp), 32'(ed));
        if (ei) chk("imem_rdata", imem_rdata, pmem_rdata);
        if (ed) chk("dmem_rdata", dmem_rdata, pmem_rdata);
        if (ei) i_pend = 0;
        if (ed) d_pend = 0;
    endtask

    task automatic cyc();
        settle_check();
        tick();
    endtask

    initial begin
        string seq, want;
        rst = 0; imem_address = 32'h10; imem_read = 1;
        dmem_address = 32'h10; dmem_wdata = 32'h55; dmem_byte_enable = 4'h5;
        dmem_read = 1; dmem_write = 1; pmem_rdata = '0; pmem_resp = 0;
        #1;

        // Reset with every request high.
        tick();
        cyc();
        settle_check();
        chk("rst_pmem_read", 32'(pmem_read), 32'd0);
        chk("rst_pmem_write", 32'(pmem_write), 32'd0);
        chk("rst_pmem_addr", pmem_address, 32'd0);
        chk("rst_dmem_resp", 32'(dmem_resp), 32'd0);
        rst = 1;
        tick();
        settle_check();
        chk("post_rst_data_first", 32'(pmem_write), 32'd1);
        chk("post_rst_read", 32'(pmem_read), 32'd0);
        pmem_resp = 1;
        settle_check();
        chk("post_rst_dresp", 32'(dmem_resp), 32'd1);
        tick();
        pmem_resp = 0; dmem_read = 0; dmem_write = 0;
        cyc();
        pmem_resp = 1;
        settle_check();
        chk("post_rst_iresp", 32'(imem_resp), 32'd1);
        tick();
        pmem_resp = 0; imem_read = 0;
        cyc();

        // Lone fetch, memory answers 3 cycles after the strobe.
        imem_read = 1; imem_address = 32'h60;
        cyc();
        settle_check();
        chk("fetch_read", 32'(pmem_read), 32'd1);
        chk("fetch_addr", pmem_address, 32'h60);
        chk("fetch_be", 32'(pmem_byte_enable), 32'hF);
        tick();
        cyc();
        cyc();
        pmem_resp = 1; pmem_rdata = 32'h13;
        settle_check();
        chk("fetch_resp", 32'(imem_resp), 32'd1);
        chk("fetch_rdata", imem_rdata, 32'h13);
        tick();
        pmem_resp = 0; imem_read = 0;
        settle_check();
        chk("fetch_resp_pulse", 32'(imem_resp), 32'd0);
        tick();

        // Store.
        dmem_write = 1; dmem_address = 32'h104;
        dmem_wdata = 32'hDEADBEEF; dmem_byte_enable = 4'b0011;
        cyc();
        dmem_address = 32'h999; dmem_wdata = 32'h1;
        settle_check();
        chk("st_write", 32'(pmem_write), 32'd1);
        chk("st_read", 32'(pmem_read), 32'd0);
        chk("st_addr", pmem_address, 32'h104);
        chk("st_wdata", pmem_wdata, 32'hDEADBEEF);
        chk("st_be", 32'(pmem_byte_enable), 32'h3);
        tick();
        pmem_resp = 1;
        settle_check();
        chk("st_resp", 32'(dmem_resp), 32'd1);
        tick();
        pmem_resp = 0; dmem_write = 0;
        cyc();

        // Contention: both held, each grant answered next cycle.
        imem_read = 1; imem_address = 32'h300;
        dmem_read = 1; dmem_address = 32'h400;
        seq = "";
        for (int g = 0; g < 10; g++) begin
            cyc();
            settle_check();
            seq = {seq, (pmem_address == 32'h400) ? "D" : "I"};
            tick();
            pmem_resp = 1;
            cyc();
            pmem_resp = 0;
        end
        want = "DDDDIDDDDI";
        n_cmp++;
        if (seq != want) begin
            n_bad++;
            $display("FAIL contention_order: got %s want %s", seq, want);
        end
        imem_read = 0; dmem_read = 0;
        cyc();

        // Mid-op reset, then a late response.
        imem_read = 1; imem_address = 32'h80;
        cyc();
        settle_check();
        chk("midop_strobe", 32'(pmem_read), 32'd1);
        tick();
        rst = 0; imem_read = 0;
        cyc();
        rst = 1; pmem_resp = 1;
        settle_check();
        chk("midop_iresp", 32'(imem_resp), 32'd0);
        chk("midop_dresp", 32'(dmem_resp), 32'd0);
        tick();
        pmem_resp = 0;
        settle_check();
        chk("midop_idle_rd", 32'(pmem_read), 32'd0);
        chk("midop_idle_wr", 32'(pmem_write), 32'd0);
        tick();

        // Read and write both set.
        dmem_read = 1; dmem_write = 1; dmem_address = 32'h200;
        cyc();
        settle_check();
        chk("rw_write", 32'(pmem_write), 32'd1);
        chk("rw_read", 32'(pmem_read), 32'd0);
        chk("rw_addr", pmem_address, 32'h200);
        tick();
        pmem_resp = 1;
        cyc();
        pmem_resp = 0; dmem_read = 0; dmem_write = 0;
        cyc();

        // Randomized traffic.
        i_pend = 0; d_pend = 0;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) != 0);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; imem_address = $urandom;
            end else if (i_pend && m_own != 2 && $urandom_range(0, 29) == 0) begin
                i_pend = 0;
            end
            if (m_own == 2 && $urandom_range(0, 3) == 0)
                imem_address = $urandom;
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                int op;
                d_pend = 1;
                dmem_address = $urandom; dmem_wdata = $urandom;
                dmem_byte_enable = 4'($urandom);
                op = $urandom_range(0, 2);
                d_r = (op != 1); d_w = (op != 0);
            end else if (d_pend && m_own != 1 && $urandom_range(0, 29) == 0) begin
                d_pend = 0;
            end
            if (m_own == 1 && $urandom_range(0, 3) == 0) begin
                dmem_address = $urandom; dmem_wdata = $urandom;
            end
            imem_read  = i_pend;
            dmem_read  = d_pend && d_r;
            dmem_write = d_pend && d_w;
            pmem_rdata = $urandom;
            pmem_resp  = (m_own != 0) ? ($urandom_range(0, 2) == 0)
                                      : ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
